// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the fetch/load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int RD_LATENCY_MIN      = 1;
  localparam int RD_LATENCY_MAX      = 4;
  localparam int MAX_DATA_STREAK_MIN = 1;
  localparam int MAX_DATA_STREAK_MAX = 15;
  localparam int STARVE_W            = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the single SRAM port, seen from the arbiter (slave)
// and from the core/SRAM environment (master).
// Handshake: a requester raises *_req and holds it and its payload stable until
// it sees *_addr_ok high in the same cycle; *_data_ok pulses for one cycle per
// accepted request, in acceptance order, and *_rdata is valid only in that cycle.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Delay line of {valid, owner} tags matching the SRAM read latency, so each
// returning word is steered to the requester that issued it.
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one SRAM port: data side
// wins, but fetch is forced through after MAX_DATA_STREAK consecutive data wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY      = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [STARVE_W-1:0] o_starve_cnt
);

  localparam logic [STARVE_W-1:0] STREAK_LIMIT = STARVE_W'(MAX_DATA_STREAK);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_force_inst;
  logic                w_grant_inst;
  logic                w_grant_data;
  tag_t                w_tag_in;
  tag_t                w_tag_out;

  // Fetch only overrides a pending data request once the streak limit is hit.
  assign w_force_inst = (r_starve_cnt == STREAK_LIMIT);
  assign w_grant_data = !reset && bus.data_req && !(bus.inst_req && w_force_inst);
  assign w_grant_inst = !reset && bus.inst_req && (!bus.data_req || w_force_inst);

  always_ff @(posedge clk) begin
    if (reset || w_grant_inst || !bus.inst_req) begin
      r_starve_cnt <= '0;
    end else if (w_grant_data && (r_starve_cnt != STREAK_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_grant_inst || w_grant_data;
    w_tag_in.owner = w_grant_data ? OWN_DATA : OWN_INST;
  end

  resp_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  always_comb begin
    bus.inst_addr_ok = w_grant_inst;
    bus.data_addr_ok = w_grant_data;
    bus.sram_en      = w_grant_inst || w_grant_data;
    bus.sram_we      = (w_grant_data && bus.data_wr) ? bus.data_wstrb : 4'b0000;
    bus.sram_addr    = w_grant_data ? bus.data_addr :
                       (w_grant_inst ? bus.inst_addr : 32'h0);
    bus.sram_wdata   = w_grant_data ? bus.data_wdata : 32'h0;
  end

  // Reset gates the response strobes so nothing in flight leaks out.
  always_comb begin
    bus.inst_data_ok = !reset && w_tag_out.valid && (w_tag_out.owner == OWN_INST);
    bus.data_data_ok = !reset && w_tag_out.valid && (w_tag_out.owner == OWN_DATA);
    bus.inst_rdata   = bus.sram_rdata;
    bus.data_rdata   = bus.sram_rdata;
  end

  assign o_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at RD_LATENCY=1 and one at RD_LATENCY=3, each
// in front of a small behavioural SRAM preloaded with 0xC0DE0000 | word_index.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter_if if1();
  mem_port_arbiter_if if3();
  logic [3:0] starve1;
  logic [3:0] starve3;

  mem_port_arbiter #(.RD_LATENCY(1), .MAX_DATA_STREAK(4)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .o_starve_cnt(starve1)
  );
  mem_port_arbiter #(.RD_LATENCY(3), .MAX_DATA_STREAK(4)) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave), .o_starve_cnt(starve3)
  );

  // SRAM models: read-before-write, data visible RD_LATENCY cycles after enable.
  logic [31:0] mem1 [256];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'hC0DE0000 | 32'(i);
    end else if (if1.sram_en) begin
      rd1 <= mem1[if1.sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (if1.sram_we[b]) mem1[if1.sram_addr[9:2]][8*b +: 8] <= if1.sram_wdata[8*b +: 8];
    end
  end
  assign if1.sram_rdata = rd1;

  logic [31:0] mem3 [256];
  logic [31:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'hC0DE0000 | 32'(i);
    end else if (if3.sram_en) begin
      p3_0 <= mem3[if3.sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (if3.sram_we[b]) mem3[if3.sram_addr[9:2]][8*b +: 8] <= if3.sram_wdata[8*b +: 8];
    end
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign if3.sram_rdata = p3_2;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_all();
    if1.inst_req = 0; if1.inst_addr = 0;
    if1.data_req = 0; if1.data_wr = 0; if1.data_wstrb = 0; if1.data_addr = 0; if1.data_wdata = 0;
    if3.inst_req = 0; if3.inst_addr = 0;
    if3.data_req = 0; if3.data_wr = 0; if3.data_wstrb = 0; if3.data_addr = 0; if3.data_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    if1.inst_req = 1; if1.data_req = 1; if1.data_wr = 1; if1.data_wstrb = 4'hF;
    if3.inst_req = 1; if3.data_req = 1; if3.data_wr = 1; if3.data_wstrb = 4'hF;
    repeat (2) @(posedge clk);
    sample();
    n_cmp++;
    if ({if1.inst_addr_ok, if1.data_addr_ok, if1.sram_en, if1.inst_data_ok, if1.data_data_ok} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes1: got %b expected 00000",
        {if1.inst_addr_ok, if1.data_addr_ok, if1.sram_en, if1.inst_data_ok, if1.data_data_ok});
    end
    n_cmp++;
    if ({if3.inst_addr_ok, if3.data_addr_ok, if3.sram_en, if3.inst_data_ok, if3.data_data_ok} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes3: got %b expected 00000",
        {if3.inst_addr_ok, if3.data_addr_ok, if3.sram_en, if3.inst_data_ok, if3.data_data_ok});
    end
    n_cmp++;
    if (if1.sram_we !== 4'h0) begin
      n_err++; $display("FAIL reset_we: got %h expected 0", if1.sram_we);
    end
    n_cmp++;
    if (starve1 !== 4'd0 || starve3 !== 4'd0) begin
      n_err++; $display("FAIL reset_starve: got %0d/%0d expected 0/0", starve1, starve3);
    end
    next_cycle();
    reset = 1'b0;
    idle_all();
    sample();
    n_cmp++;
    if (if1.sram_en !== 1'b0 || if3.sram_en !== 1'b0) begin
      n_err++; $display("FAIL idle_en: got %b%b expected 00", if1.sram_en, if3.sram_en);
    end
  endtask

  task automatic test_inst_only();
    logic        req_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] adr_t [4] = '{32'h1c000000, 32'h1c000004, 32'h0, 32'h0};
    logic        aok_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        dok_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd_t  [4] = '{32'h0, 32'hC0DE0000, 32'hC0DE0001, 32'h0};
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      if1.inst_req = req_t[c]; if1.inst_addr = adr_t[c];
      sample();
      n_cmp++;
      if (if1.inst_addr_ok !== aok_t[c] || if1.sram_en !== aok_t[c]) begin
        n_err++; $display("FAIL inst_aok c%0d: got aok=%b en=%b expected %b", c, if1.inst_addr_ok, if1.sram_en, aok_t[c]);
      end
      n_cmp++;
      if (if1.sram_we !== 4'h0 || if1.data_data_ok !== 1'b0) begin
        n_err++; $display("FAIL inst_we c%0d: got we=%h dok=%b expected 0/0", c, if1.sram_we, if1.data_data_ok);
      end
      if (aok_t[c]) begin
        n_cmp++;
        if (if1.sram_addr !== adr_t[c] || if1.sram_wdata !== 32'h0) begin
          n_err++; $display("FAIL inst_addr c%0d: got %h/%h expected %h/0", c, if1.sram_addr, if1.sram_wdata, adr_t[c]);
        end
      end
      n_cmp++;
      if (if1.inst_data_ok !== dok_t[c]) begin
        n_err++; $display("FAIL inst_dok c%0d: got %b expected %b", c, if1.inst_data_ok, dok_t[c]);
      end
      if (dok_t[c]) begin
        n_cmp++;
        if (if1.inst_rdata !== rd_t[c]) begin
          n_err++; $display("FAIL inst_rdata c%0d: got %h expected %h", c, if1.inst_rdata, rd_t[c]);
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic        req_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        wr_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  stb_t [6] = '{4'hF, 4'hF, 4'h3, 4'hF, 4'h0, 4'h0};
    logic [31:0] wd_t  [6] = '{32'hDEADBEEF, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0};
    logic [3:0]  we_t  [6] = '{4'hF, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0};
    logic        dok_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        chk_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] rd_t  [6] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEAD5678, 32'h0};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if1.data_req = req_t[c]; if1.data_wr = wr_t[c]; if1.data_wstrb = stb_t[c];
      if1.data_addr = 32'h100; if1.data_wdata = wd_t[c];
      sample();
      n_cmp++;
      if (if1.data_addr_ok !== req_t[c] || if1.inst_addr_ok !== 1'b0) begin
        n_err++; $display("FAIL st_aok c%0d: got d=%b i=%b expected %b/0", c, if1.data_addr_ok, if1.inst_addr_ok, req_t[c]);
      end
      n_cmp++;
      if (if1.sram_we !== we_t[c]) begin
        n_err++; $display("FAIL st_we c%0d: got %h expected %h", c, if1.sram_we, we_t[c]);
      end
      if (req_t[c]) begin
        n_cmp++;
        if (if1.sram_addr !== 32'h100 || if1.sram_wdata !== wd_t[c]) begin
          n_err++; $display("FAIL st_bus c%0d: got %h/%h expected 100/%h", c, if1.sram_addr, if1.sram_wdata, wd_t[c]);
        end
      end
      n_cmp++;
      if (if1.data_data_ok !== dok_t[c] || if1.inst_data_ok !== 1'b0) begin
        n_err++; $display("FAIL st_dok c%0d: got d=%b i=%b expected %b/0", c, if1.data_data_ok, if1.inst_data_ok, dok_t[c]);
      end
      if (chk_t[c]) begin
        n_cmp++;
        if (if1.data_rdata !== rd_t[c]) begin
          n_err++; $display("FAIL ld_rdata c%0d: got %h expected %h", c, if1.data_rdata, rd_t[c]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int run = 0;
    int max_run = 0;
    next_cycle();
    if1.inst_req = 1; if1.inst_addr = 32'h1c000010;
    if1.data_req = 1; if1.data_wr = 0; if1.data_wstrb = 4'h0; if1.data_addr = 32'h104;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) next_cycle();
      sample();
      n_cmp++;
      if (if1.inst_addr_ok !== (i % 5 == 4) || if1.data_addr_ok !== (i % 5 != 4)) begin
        n_err++; $display("FAIL cont_grant c%0d: got i=%b d=%b expected i=%b", i, if1.inst_addr_ok, if1.data_addr_ok, (i % 5 == 4));
      end
      n_cmp++;
      if (starve1 !== 4'(i % 5)) begin
        n_err++; $display("FAIL cont_starve c%0d: got %0d expected %0d", i, starve1, i % 5);
      end
      n_cmp++;
      if (if1.inst_data_ok !== (i % 5 == 0 && i > 0) || if1.data_data_ok !== (i % 5 != 0)) begin
        n_err++; $display("FAIL cont_route c%0d: got i=%b d=%b", i, if1.inst_data_ok, if1.data_data_ok);
      end
      if (i % 5 == 0 && i > 0) begin
        n_cmp++;
        if (if1.inst_rdata !== 32'hC0DE0004) begin
          n_err++; $display("FAIL cont_rdata c%0d: got %h expected c0de0004", i, if1.inst_rdata);
        end
      end
      if (if1.inst_addr_ok === 1'b1) run = 0;
      else run++;
      if (run > max_run) max_run = run;
    end
    n_cmp++;
    if (max_run !== 4) begin
      n_err++; $display("FAIL cont_maxblock: got %0d expected 4", max_run);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_alternate();
    logic        ir_t  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        dr_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] adr_t [7] = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        idk_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        ddk_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] rd_t  [7] = '{32'h0, 32'h0, 32'h0, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'h0};
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if3.inst_req = ir_t[c]; if3.inst_addr = adr_t[c];
      if3.data_req = dr_t[c]; if3.data_wr = 0; if3.data_addr = adr_t[c];
      sample();
      n_cmp++;
      if (if3.inst_addr_ok !== ir_t[c] || if3.data_addr_ok !== dr_t[c]) begin
        n_err++; $display("FAIL alt_aok c%0d: got i=%b d=%b expected i=%b d=%b", c, if3.inst_addr_ok, if3.data_addr_ok, ir_t[c], dr_t[c]);
      end
      n_cmp++;
      if (if3.inst_data_ok !== idk_t[c] || if3.data_data_ok !== ddk_t[c]) begin
        n_err++; $display("FAIL alt_dok c%0d: got i=%b d=%b expected i=%b d=%b", c, if3.inst_data_ok, if3.data_data_ok, idk_t[c], ddk_t[c]);
      end
      if (idk_t[c] || ddk_t[c]) begin
        n_cmp++;
        if ((idk_t[c] ? if3.inst_rdata : if3.data_rdata) !== rd_t[c]) begin
          n_err++; $display("FAIL alt_rdata c%0d: got %h expected %h", c, idk_t[c] ? if3.inst_rdata : if3.data_rdata, rd_t[c]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic       rst_t [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rq_t  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ddk_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       cs_t  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] st_t  [10] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      reset = rst_t[c];
      if3.inst_req = rq_t[c]; if3.inst_addr = 32'h1c000000;
      if3.data_req = rq_t[c]; if3.data_wr = 0; if3.data_addr = 32'h0;
      sample();
      n_cmp++;
      if (if3.data_addr_ok !== rq_t[c] || if3.inst_addr_ok !== 1'b0) begin
        n_err++; $display("FAIL rst_aok c%0d: got d=%b i=%b expected %b/0", c, if3.data_addr_ok, if3.inst_addr_ok, rq_t[c]);
      end
      n_cmp++;
      if (if3.data_data_ok !== ddk_t[c] || if3.inst_data_ok !== 1'b0) begin
        n_err++; $display("FAIL rst_dok c%0d: got d=%b i=%b expected %b/0", c, if3.data_data_ok, if3.inst_data_ok, ddk_t[c]);
      end
      if (cs_t[c]) begin
        n_cmp++;
        if (starve3 !== st_t[c]) begin
          n_err++; $display("FAIL rst_starve c%0d: got %0d expected %0d", c, starve3, st_t[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_inst_only();
    test_store_load();
    test_contention();
    test_alternate();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the instruction-fetch requester and the load/store requester.
- Both requesters use a req/addr_ok/data_ok split handshake.
- Grants at most one request per cycle. Data side has priority; a starvation counter bounds how long instruction fetch can be blocked.
- Tracks in-flight requests in a tag pipeline so every response is routed back to its owner.
- Sits between the CPU core's fetch/memory stages and the unified memory, replacing the separate inst/data SRAM ports.

Parameters:
- RD_LATENCY, 1: SRAM cycles from accepted address to valid sram_rdata. Legal range 1..4.
- MAX_DATA_STREAK, 4: maximum consecutive data grants while inst_req is pending before instruction fetch is forced through. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch word address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load data valid, or store completed
- data_rdata  out  32  load data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data

Behaviour:
- Reset: synchronous, active-high. Clears the tag pipeline valids and the starvation counter.
- While reset is high: addr_ok outputs = 0, sram_en = 0, sram_we = 0, data_ok outputs = 0.
- Responses in flight when reset asserts are discarded; they never produce data_ok.
- Grant is combinational in cycle t:
  - data_req only: grant data.
  - inst_req only: grant inst.
  - both asserted: grant inst if starve_cnt == MAX_DATA_STREAK, otherwise grant data.
  - neither: no grant, sram_en = 0.
- The granted side sees addr_ok = 1 in cycle t; the loser sees addr_ok = 0 and must hold its request stable.
- SRAM drive in cycle t:
  - sram_en = 1 on any grant.
  - sram_addr and sram_wdata come from the granted side.
  - sram_we = data_wstrb when data_wr is granted, otherwise 0.
  - sram_wdata is 0 for inst grants.
- Starvation counter (4 bits), updated at posedge:
  - increment when data is granted while inst_req = 1;
  - clear when inst is granted or inst_req = 0;
  - saturates at MAX_DATA_STREAK.
- Tag pipeline: RD_LATENCY stages, each holding {valid, owner}. Stage 0 loads {grant, owner} at the end of cycle t; stages shift every cycle.
- The last stage becomes valid in cycle t+RD_LATENCY. In that cycle the owner's data_ok = 1 and its rdata = sram_rdata.
- Stores also produce data_data_ok at t+RD_LATENCY; data_rdata content is don't-care for stores.
- Back-to-back grants every cycle are legal. Up to RD_LATENCY requests are in flight, and responses return in grant order.
- Only the owner's data_ok asserts; the other side's data_ok = 0. Both rdata outputs may show sram_rdata at any time and are meaningful only when the matching data_ok is high.
- A request and a response for the same side in the same cycle are legal and independent.
- Address alignment and width checks are the requester's responsibility; the arbiter passes addresses unchanged.

Decomposition:
- Shared package mem_arb_pkg:
  - owner type: OWN_INST = 0, OWN_DATA = 1;
  - tag struct {valid, owner};
  - bounds for RD_LATENCY_MAX and MAX_DATA_STREAK.
- One sub-module, resp_tag_pipe: a parameterised RD_LATENCY-deep shift register of tags with synchronous clear, outputting the last-stage tag.
- Grant logic and the starvation counter stay in the top module.

Test Plan:
- Inst only, RD_LATENCY=1: inst_req=1 with addr 0x1c000000, 0x1c000004 on consecutive cycles -> inst_addr_ok=1 each cycle; inst_data_ok=1 one cycle later each time; inst_rdata equals the SRAM words; sram_we=0.
- Store then load, both from data side: store addr 0x100, wstrb 0xF, wdata 0xDEADBEEF; next cycle load 0x100 -> sram_we=0xF in the store cycle; store data_ok at t+1; load data_ok at t+2 with data_rdata=0xDEADBEEF.
- Contention, MAX_DATA_STREAK=4: inst_req and data_req held high -> pattern is 4 data grants, 1 inst grant, repeating; inst_addr_ok never low more than 4 cycles in a row.
- RD_LATENCY=3, alternating grants inst, data, inst -> each data_ok lands exactly 3 cycles after its addr_ok, routed to the correct side, in order.
- Reset with 2 requests in flight (RD_LATENCY=3) -> no data_ok asserts after reset; starve_cnt = 0; first post-reset grant follows the normal priority rules.
